// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard control path.
// State encoding, point codes and default score geometry.
package placar_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      APPLY        = 2'd2,
      WAIT_RELEASE = 2'd3
   } estado_t;

   localparam logic [1:0] PTS_1 = 2'd1;
   localparam logic [1:0] PTS_2 = 2'd2;
   localparam logic [1:0] PTS_3 = 2'd3;

   localparam int MAX_SCORE = 99;
   localparam int SCORE_W   = 7;

   // 0 unless exactly one button is pressed
   function automatic logic [1:0] codigo(input logic [2:0] b);
      logic [1:0] c;
      c = 2'd0;
      unique case (1'b1)
         (b == 3'b001): c = PTS_1;
         (b == 3'b010): c = PTS_2;
         (b == 3'b100): c = PTS_3;
         default:       c = 2'd0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] mascara(input logic [1:0] c);
      logic [2:0] m;
      m = 3'b000;
      unique case (1'b1)
         (c == PTS_1): m = 3'b001;
         (c == PTS_2): m = 3'b010;
         (c == PTS_3): m = 3'b100;
         default:      m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/controle_placar_if.sv
// Button/switch inputs and score outputs of the scoreboard controller.
// BUZINA_EN adds the buzina output.
interface controle_placar_if #(
   parameter int SCORE_W = 7
);
   logic               btn_a_n;
   logic               btn_b_n;
   logic               btn_c_n;
   logic               sw_sub;
   logic               sw_team;
   logic               clr_placar;
   logic [SCORE_W-1:0] score_t0;
   logic [SCORE_W-1:0] score_t1;
   logic [SCORE_W-1:0] score_sel;
   logic [1:0]         pontos;
   logic               atualizou;
   logic               erro;
`ifdef BUZINA_EN
   logic               buzina;

   modport master (
      output btn_a_n, btn_b_n, btn_c_n, sw_sub, sw_team, clr_placar,
      input  score_t0, score_t1, score_sel, pontos, atualizou, erro,
      input  buzina
   );
   modport slave (
      input  btn_a_n, btn_b_n, btn_c_n, sw_sub, sw_team, clr_placar,
      output score_t0, score_t1, score_sel, pontos, atualizou, erro,
      output buzina
   );
`else
   modport master (
      output btn_a_n, btn_b_n, btn_c_n, sw_sub, sw_team, clr_placar,
      input  score_t0, score_t1, score_sel, pontos, atualizou, erro
   );
   modport slave (
      input  btn_a_n, btn_b_n, btn_c_n, sw_sub, sw_team, clr_placar,
      output score_t0, score_t1, score_sel, pontos, atualizou, erro
   );
`endif
endinterface

// File: rtl/controle_placar_sincronizador.sv
// Two-flop synchronizer for the three point buttons.
// Converts active-low raw inputs to active-high.
module sincronizador_botoes (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] btn_n,
   output logic [2:0] btn
);
   logic [2:0] s1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1  <= 3'b000;
         btn <= 3'b000;
      end else begin
         s1  <= ~btn_n;
         btn <= s1;
      end
   end
endmodule

// File: rtl/controle_placar.sv
// Scoreboard control: debounce, score registers, accept/reject.
// Optional buzzer output when BUZINA_EN is defined.
module controle_placar
   import placar_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_SCORE       = placar_pkg::MAX_SCORE,
   parameter int SCORE_W         = placar_pkg::SCORE_W
) (
   input logic              clk,
   input logic              reset,
   controle_placar_if.slave bus
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_DEB   = DEBOUNCE;
   localparam logic [1:0] S_APPLY = APPLY;
   localparam logic [1:0] S_WAIT  = WAIT_RELEASE;
   localparam int         CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]         btn;
   logic [1:0]         estado;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         cod;
   logic [1:0]         pontos_q;
   logic [SCORE_W-1:0] t0;
   logic [SCORE_W-1:0] t1;
   logic               atu;
   logic               err;

   logic [SCORE_W-1:0] cur;
   logic [SCORE_W:0]   soma;
   logic [SCORE_W-1:0] novo;
   logic               rejeita;

   sincronizador_botoes u_sinc (
      .clk   (clk),
      .reset (reset),
      .btn_n ({bus.btn_c_n, bus.btn_b_n, bus.btn_a_n}),
      .btn   (btn)
   );

   always_comb begin
      cur  = bus.sw_team ? t1 : t0;
      soma = {1'b0, cur} + (SCORE_W+1)'(cod);
      if (bus.sw_sub) begin
         rejeita = SCORE_W'(cod) > cur;
         novo    = cur - SCORE_W'(cod);
      end else begin
         rejeita = soma > (SCORE_W+1)'(MAX_SCORE);
         novo    = soma[SCORE_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado   <= S_IDLE;
         cnt      <= '0;
         cod      <= 2'd0;
         pontos_q <= 2'd0;
         t0       <= '0;
         t1       <= '0;
         atu      <= 1'b0;
         err      <= 1'b0;
      end else begin
         atu <= 1'b0;
         err <= 1'b0;
         unique case (estado)
            S_IDLE: begin
               if (codigo(btn) != 2'd0) begin
                  cod    <= codigo(btn);
                  cnt    <= '0;
                  estado <= S_DEB;
               end
            end
            S_DEB: begin
               if (btn != mascara(cod))
                  estado <= S_IDLE;
               else if (cnt == LAST)
                  estado <= S_APPLY;
               else
                  cnt <= cnt + 1'b1;
            end
            S_APPLY: begin
               estado <= S_WAIT;
               if (!bus.clr_placar) begin
                  if (rejeita) begin
                     err <= 1'b1;
                  end else begin
                     atu      <= 1'b1;
                     pontos_q <= cod;
                     if (bus.sw_team) t1 <= novo;
                     else             t0 <= novo;
                  end
               end
            end
            S_WAIT: begin
               if (btn == 3'b000) estado <= S_IDLE;
            end
            default: estado <= S_IDLE;
         endcase
         // clear overrides any update made in the same cycle
         if (bus.clr_placar) begin
            t0       <= '0;
            t1       <= '0;
            pontos_q <= 2'd0;
         end
      end
   end

   assign bus.score_t0  = t0;
   assign bus.score_t1  = t1;
   assign bus.score_sel = bus.sw_team ? t1 : t0;
   assign bus.pontos    = pontos_q;
   assign bus.atualizou = atu;
   assign bus.erro      = err;

`ifdef BUZINA_EN
   localparam int BUZINA_CYCLES = 25_000_000;
   logic [24:0] buz_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         buz_cnt <= '0;
      else if (err)
         buz_cnt <= 25'(BUZINA_CYCLES);
      else if (buz_cnt != '0)
         buz_cnt <= buz_cnt - 1'b1;
   end

   assign bus.buzina = buz_cnt != '0;
`endif
endmodule

// File: tb/tb_controle_placar.sv
// Bench for controle_placar with a 4-cycle debounce.
// Scores are predicted from the press rules with plain arithmetic.
module tb_controle_placar;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   controle_placar_if #(.SCORE_W(7)) bus ();

   controle_placar #(
      .DEBOUNCE_CYCLES (4),
      .MAX_SCORE       (99),
      .SCORE_W         (7)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int na    = 0;
   int ne    = 0;
   int m0    = 0;
   int m1    = 0;
   int mp    = 0;

   always @(negedge clk) begin
      if (bus.atualizou === 1'b1) na++;
      if (bus.erro === 1'b1)      ne++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.btn_a_n    = 1'b1;
      bus.btn_b_n    = 1'b1;
      bus.btn_c_n    = 1'b1;
      bus.clr_placar = 1'b0;
   endtask

   task automatic check_all(input string tag, input bit team,
                            input int ea, input int ee);
      chk({tag, ".t0"},  32'(bus.score_t0), 32'(m0));
      chk({tag, ".t1"},  32'(bus.score_t1), 32'(m1));
      chk({tag, ".pts"}, 32'(bus.pontos),   32'(mp));
      chk({tag, ".atu"}, 32'(na),           32'(ea));
      chk({tag, ".err"}, 32'(ne),           32'(ee));
      chk({tag, ".sel"}, 32'(bus.score_sel), 32'(team ? m1 : m0));
   endtask

   // mask bit0=A(+1) bit1=B(+2) bit2=C(+3); short holds never qualify
   task automatic press(input logic [2:0] mask, input bit team,
                        input bit sub, input int hold, input string tag);
      int ea, ee, pts, cur;
      @(negedge clk);
      bus.sw_team = team;
      bus.sw_sub  = sub;
      na = 0;
      ne = 0;
      {bus.btn_c_n, bus.btn_b_n, bus.btn_a_n} = ~mask;
      repeat (hold) @(negedge clk);
      idle_inputs();
      repeat (8) @(negedge clk);
      ea = 0;
      ee = 0;
      if ($countones(mask) == 1 && hold >= 8) begin
         pts = mask[0] ? 1 : (mask[1] ? 2 : 3);
         cur = team ? m1 : m0;
         if (sub) begin
            if (pts > cur) ee = 1;
            else cur = cur - pts;
         end else begin
            if (cur + pts > 99) ee = 1;
            else cur = cur + pts;
         end
         if (ee == 0) begin
            ea = 1;
            mp = pts;
            if (team) m1 = cur;
            else      m0 = cur;
         end
      end
      check_all(tag, team, ea, ee);
   endtask

   initial begin
      logic [2:0] combos [4];
      logic [2:0] mask;
      int hold;
      combos[0] = 3'b011;
      combos[1] = 3'b101;
      combos[2] = 3'b110;
      combos[3] = 3'b111;

      reset = 1'b1;
      idle_inputs();
      bus.sw_team = 1'b0;
      bus.sw_sub  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      na = 0;
      ne = 0;
      chk("rst.t0",  32'(bus.score_t0),  0);
      chk("rst.t1",  32'(bus.score_t1),  0);
      chk("rst.pts", 32'(bus.pontos),    0);
      chk("rst.atu", 32'(bus.atualizou), 0);
      chk("rst.err", 32'(bus.erro),      0);

      press(3'b010, 0, 0, 10, "b_add");
      chk("b_add.abs", 32'(bus.score_t0), 2);
      press(3'b001, 0, 0, 2, "a_short");

      for (int i = 0; i < 32; i++) press(3'b100, 1, 0, 10, "fill");
      press(3'b010, 1, 0, 10, "fill98");
      chk("fill98.abs", 32'(bus.score_t1), 98);
      press(3'b100, 1, 0, 10, "ovf");
      chk("ovf.abs", 32'(bus.score_t1), 98);
      chk("ovf.err", 32'(ne), 1);
`ifdef BUZINA_EN
      chk("ovf.buzina", 32'(bus.buzina), 1);
`endif

      for (int i = 0; i < 32; i++) press(3'b100, 1, 1, 10, "drain");
      chk("drain.abs", 32'(bus.score_t1), 2);
      press(3'b100, 1, 1, 10, "undf");
      chk("undf.abs", 32'(bus.score_t1), 2);
      press(3'b010, 1, 1, 10, "sub0");
      chk("sub0.abs", 32'(bus.score_t1), 0);

      press(3'b101, 0, 0, 10, "a_c");
      press(3'b001, 0, 0, 100, "hold100");
      chk("hold100.abs", 32'(bus.score_t0), 3);

      press(3'b100, 1, 0, 10, "pre_clr");
      // clear spans the whole window where the press can be applied
      @(negedge clk);
      na = 0;
      ne = 0;
      bus.sw_team = 1'b0;
      bus.sw_sub  = 1'b0;
      bus.btn_b_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.clr_placar = 1'b1;
      repeat (4) @(negedge clk);
      bus.clr_placar = 1'b0;
      repeat (2) @(negedge clk);
      idle_inputs();
      repeat (8) @(negedge clk);
      m0 = 0;
      m1 = 0;
      mp = 0;
      check_all("clr_apply", 0, 0, 0);

      press(3'b010, 0, 0, 10, "pre_rst");
      @(negedge clk);
      bus.btn_a_n = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      na = 0;
      ne = 0;
      m0 = 0;
      m1 = 0;
      mp = 0;
      check_all("rst_deb", 0, 0, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      press(3'b010, 1, 0, 10, "post_rst");

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            mask = 3'b001 << $urandom_range(0, 2);
         end else begin
            mask = combos[$urandom_range(0, 3)];
         end
         if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
         else hold = $urandom_range(8, 14);
         press(mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               hold, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
